lvds_word_align: RTL and testbench
==================================

LVDS_WORD_ALIGN -- requirements
Module: lvds_word_align

Interface
REQ-001 Parameter TRAIN_PAT, default 7'b1100011: expected per-lane 7-bit training word.
REQ-002 Parameter MATCH_CNT, default 16: consecutive matching words required to declare lock.
REQ-003 Parameter SLIP_WAIT, default 4: idle cycles after each bitslip pulse before re-compare.
REQ-004 Parameter MAX_SLIP, default 14: bitslip pulses allowed per lane before declaring failure.
REQ-005 clkdiv  in  1  sole clock (divided parallel-word clock); all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 train_en  in  1  training request; a rising edge (re)starts alignment of all lanes.
REQ-008 dat_in  in  28  deserialized words; lane i = dat_in[i*7+6:i*7], bit i*7 is the first-received bit.
REQ-009 bitslip  out  4  one-cycle bitslip pulse per lane, to the deserializer BITSLIP inputs.
REQ-010 lane_locked  out  4  per-lane lock status.
REQ-011 lane_fail  out  4  per-lane alignment failure status.
REQ-012 all_locked  out  1  AND of lane_locked.
REQ-013 dat_out  out  28  registered copy of dat_in.
REQ-014 dat_valid  out  1  high when all_locked is high and train_en is low.

Function
REQ-015 Four independent per-lane FSMs with states IDLE, CHECK, SLIP, WAIT, LOCKED, FAIL, plus per-lane match counter (5 bits) and slip counter (4 bits).
REQ-016 train_en rising edge (registered 0 to 1) SHALL move every lane to CHECK and clear its counters, whatever its current state.
REQ-017 IDLE: hold; bitslip=0.
REQ-018 CHECK: lane word == TRAIN_PAT increments match counter; on reaching MATCH_CNT, go to LOCKED next cycle.
REQ-019 CHECK: mismatch clears match counter; if slip counter < MAX_SLIP, go to SLIP, otherwise go to FAIL.
REQ-020 SLIP: assert bitslip[i] for exactly one cycle, increment slip counter, go to WAIT.
REQ-021 WAIT: count SLIP_WAIT cycles with words ignored, then go to CHECK.
REQ-022 LOCKED: lane_locked[i]=1; hold state and slip count until the next train_en rising edge; no action on data mismatch.
REQ-023 FAIL: lane_fail[i]=1; hold until the next train_en rising edge.
REQ-024 train_en falling while a lane is in CHECK, SLIP or WAIT: lane returns to IDLE with counters cleared; a bitslip pulse already asserted completes its single cycle.
REQ-025 bitslip pulses SHALL be spaced at least SLIP_WAIT+2 cycles apart per lane.
REQ-026 dat_out: one-cycle latency from dat_in, updated every cycle regardless of state.
REQ-027 dat_valid, all_locked, lane_locked and lane_fail SHALL be registered outputs (no combinational path from inputs).

Reset
REQ-028 While rst_n=0: all FSMs in IDLE; counters=0; bitslip=0, lane_locked=0, lane_fail=0, all_locked=0, dat_out=0, dat_valid=0; train_en edge register=0.
REQ-029 rst_n deassertion with train_en already high counts as a rising edge on the first clock after release.
REQ-030 rst_n asserted mid-training SHALL abort immediately (asynchronous), with no further bitslip pulse.

Verification
REQ-031 All lanes already carry 7'b1100011, train_en 0 to 1: no bitslip; lane_locked=4'hF and all_locked=1 within 18 cycles; dat_valid=1 after train_en drops.
REQ-032 Lane 2 rotated by 3 (behavioural model rotates one bit per pulse): exactly 3 pulses on bitslip[2] spaced >=6 cycles apart; lane 2 locks; other lanes show zero pulses.
REQ-033 Lane 0 held at 7'h00: 14 pulses, then lane_fail[0]=1, lane_locked[0]=0, all_locked=0.
REQ-034 Single corrupted word on lane 1 after 10 matches: counter clears, one slip occurs, lock is reached only after 16 fresh consecutive matches.
REQ-035 rst_n low during WAIT on lane 3: all outputs zero immediately; after release with train_en high, training restarts from CHECK.
REQ-036 train_en re-pulsed after full lock: all lanes re-enter CHECK, lane_locked clears the next cycle, and lock is reacquired.

Source files
------------

// File: rtl/lvds_word_align.sv
// Four-lane LVDS word aligner: bitslips each deserializer lane until it carries
// TRAIN_PAT for MATCH_CNT consecutive words, then reports per-lane lock or failure.
module lvds_word_align #(
    parameter logic [6:0]  TRAIN_PAT = 7'b1100011,
    parameter int unsigned MATCH_CNT = 16,
    parameter int unsigned SLIP_WAIT = 4,
    parameter int unsigned MAX_SLIP  = 14
) (
    input  logic        clkdiv,
    input  logic        rst_n,
    input  logic        train_en,
    input  logic [27:0] dat_in,
    output logic [3:0]  bitslip,
    output logic [3:0]  lane_locked,
    output logic [3:0]  lane_fail,
    output logic        all_locked,
    output logic [27:0] dat_out,
    output logic        dat_valid
);

    localparam int unsigned LANES  = 4;
    localparam int unsigned WORD_W = 7;
    localparam int unsigned MCNT_W = 5;
    localparam int unsigned SCNT_W = 4;
    localparam int unsigned WCNT_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SLIP,
        ST_WAIT,
        ST_LOCKED,
        ST_FAIL
    } state_t;

    state_t              state     [LANES];
    logic [MCNT_W-1:0]   match_cnt [LANES];
    logic [SCNT_W-1:0]   slip_cnt  [LANES];
    logic [WCNT_W-1:0]   wait_cnt  [LANES];
    logic                train_q;
    logic                train_rise_c;

    assign train_rise_c = train_en & ~train_q;

    // Per-lane alignment FSMs; a training rising edge overrides every state.
    always_ff @(posedge clkdiv or negedge rst_n) begin
        if (!rst_n) begin
            train_q     <= 1'b0;
            bitslip     <= '0;
            lane_locked <= '0;
            lane_fail   <= '0;
            for (int l = 0; l < LANES; l++) begin
                state[l]     <= ST_IDLE;
                match_cnt[l] <= '0;
                slip_cnt[l]  <= '0;
                wait_cnt[l]  <= '0;
            end
        end else begin
            train_q <= train_en;
            for (int l = 0; l < LANES; l++) begin
                bitslip[l] <= 1'b0;
                if (train_rise_c) begin
                    state[l]       <= ST_CHECK;
                    match_cnt[l]   <= '0;
                    slip_cnt[l]    <= '0;
                    wait_cnt[l]    <= '0;
                    lane_locked[l] <= 1'b0;
                    lane_fail[l]   <= 1'b0;
                end else if (!train_en && (state[l] == ST_CHECK || state[l] == ST_SLIP ||
                                           state[l] == ST_WAIT)) begin
                    // Training withdrawn mid-alignment: abandon this lane.
                    state[l]     <= ST_IDLE;
                    match_cnt[l] <= '0;
                    slip_cnt[l]  <= '0;
                    wait_cnt[l]  <= '0;
                end else begin
                    case (state[l])
                        ST_CHECK: begin
                            if (dat_in[l*WORD_W +: WORD_W] == TRAIN_PAT) begin
                                match_cnt[l] <= match_cnt[l] + 1'b1;
                                if (match_cnt[l] == MCNT_W'(MATCH_CNT - 1)) begin
                                    state[l]       <= ST_LOCKED;
                                    lane_locked[l] <= 1'b1;
                                end
                            end else begin
                                match_cnt[l] <= '0;
                                if (slip_cnt[l] < SCNT_W'(MAX_SLIP)) begin
                                    state[l]   <= ST_SLIP;
                                    bitslip[l] <= 1'b1;
                                end else begin
                                    state[l]     <= ST_FAIL;
                                    lane_fail[l] <= 1'b1;
                                end
                            end
                        end
                        ST_SLIP: begin
                            slip_cnt[l] <= slip_cnt[l] + 1'b1;
                            wait_cnt[l] <= '0;
                            state[l]    <= ST_WAIT;
                        end
                        ST_WAIT: begin
                            // Let the deserializer settle after the slip before comparing.
                            if (wait_cnt[l] == WCNT_W'(SLIP_WAIT - 1)) begin
                                state[l] <= ST_CHECK;
                            end else begin
                                wait_cnt[l] <= wait_cnt[l] + 1'b1;
                            end
                        end
                        ST_IDLE, ST_LOCKED, ST_FAIL: ;
                        default: state[l] <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    // Data pass-through and aggregate status.
    always_ff @(posedge clkdiv or negedge rst_n) begin
        if (!rst_n) begin
            dat_out    <= '0;
            all_locked <= 1'b0;
            dat_valid  <= 1'b0;
        end else begin
            dat_out    <= dat_in;
            all_locked <= &lane_locked;
            dat_valid  <= (&lane_locked) & ~train_en;
        end
    end

endmodule

// File: tb/tb_lvds_word_align.sv
// Bench for lvds_word_align: behavioural bitslip deserializer model per lane and a
// dat_out scoreboard, driven through scenario tasks.
module tb_lvds_word_align;

    localparam logic [6:0] PAT      = 7'b1100011;
    localparam int         SPACING  = 6;

    logic        clkdiv;
    logic        rst_n;
    logic        train_en;
    logic [27:0] dat_in;
    logic [3:0]  bitslip;
    logic [3:0]  lane_locked;
    logic [3:0]  lane_fail;
    logic        all_locked;
    logic [27:0] dat_out;
    logic        dat_valid;

    int          checks;
    int          failures;
    int          cyc;
    int          off        [4];
    bit          follow     [4];
    bit          ovr_en     [4];
    logic [6:0]  ovr_val    [4];
    int          pulse_cnt  [4];
    int          last_pulse [4];
    int          base       [4];
    logic [27:0] sb_q [$];

    lvds_word_align dut (
        .clkdiv      (clkdiv),
        .rst_n       (rst_n),
        .train_en    (train_en),
        .dat_in      (dat_in),
        .bitslip     (bitslip),
        .lane_locked (lane_locked),
        .lane_fail   (lane_fail),
        .all_locked  (all_locked),
        .dat_out     (dat_out),
        .dat_valid   (dat_valid)
    );

    always #5 clkdiv = ~clkdiv;

    function automatic logic [6:0] rot7(input logic [6:0] p, input int n);
        logic [6:0] r;
        r = '0;
        for (int k = 0; k < 7; k++) r[(k + n) % 7] = p[k];
        return r;
    endfunction

    // One cycle: score dat_out, observe pulses, advance the deserializer model, drive next word.
    task automatic tick();
        logic [27:0] exp_w;
        @(negedge clkdiv);
        cyc++;
        if (!rst_n) begin
            sb_q.delete();
            checks++;
            if (dat_out !== 28'h0) begin
                failures++;
                $display("FAIL dat_out_in_reset got=%h exp=0", dat_out);
            end
            checks++;
            if (bitslip !== 4'h0) begin
                failures++;
                $display("FAIL bitslip_in_reset got=%b exp=0000", bitslip);
            end
            for (int i = 0; i < 4; i++) last_pulse[i] = -1;
        end else if (sb_q.size() > 0) begin
            exp_w = sb_q.pop_front();
            checks++;
            if (dat_out !== exp_w) begin
                failures++;
                $display("FAIL dat_out got=%h exp=%h", dat_out, exp_w);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (bitslip[i] === 1'b1) begin
                pulse_cnt[i]++;
                if (last_pulse[i] >= 0) begin
                    checks++;
                    if (cyc - last_pulse[i] < SPACING) begin
                        failures++;
                        $display("FAIL pulse_spacing lane=%0d got=%0d min=%0d",
                                 i, cyc - last_pulse[i], SPACING);
                    end
                end
                last_pulse[i] = cyc;
                if (follow[i]) off[i] = (off[i] == 0) ? 6 : off[i] - 1;
            end
        end
        for (int i = 0; i < 4; i++)
            dat_in[i*7 +: 7] = ovr_en[i] ? ovr_val[i] : rot7(PAT, off[i]);
        sb_q.push_back(dat_in);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        train_en = 1'b0;
        repeat (3) tick();
        checks++;
        if (lane_locked !== 4'h0) begin failures++; $display("FAIL rst_lane_locked got=%b exp=0000", lane_locked); end
        checks++;
        if (lane_fail !== 4'h0) begin failures++; $display("FAIL rst_lane_fail got=%b exp=0000", lane_fail); end
        checks++;
        if (all_locked !== 1'b0) begin failures++; $display("FAIL rst_all_locked got=%b exp=0", all_locked); end
        checks++;
        if (dat_valid !== 1'b0) begin failures++; $display("FAIL rst_dat_valid got=%b exp=0", dat_valid); end
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (lane_locked !== 4'h0 || bitslip !== 4'h0) begin
            failures++;
            $display("FAIL idle_hold got=%b/%b exp=0000/0000", lane_locked, bitslip);
        end
    endtask

    task automatic test_aligned();
        int lock_t;
        logic [3:0] early;
        early = 4'hx;
        lock_t = 0;
        for (int i = 0; i < 4; i++) begin off[i] = 0; base[i] = pulse_cnt[i]; end
        train_en = 1'b1;
        for (int t = 1; t <= 18; t++) begin
            tick();
            if (t == 16) early = lane_locked;
            if (lock_t == 0 && all_locked === 1'b1 && lane_locked === 4'hF) lock_t = t;
        end
        checks++;
        if (lock_t == 0) begin failures++; $display("FAIL aligned_lock_18 got=%b/%b exp=1111/1", lane_locked, all_locked); end
        checks++;
        if (early !== 4'h0) begin failures++; $display("FAIL aligned_early_lock got=%b exp=0000", early); end
        checks++;
        if (dat_valid !== 1'b0) begin failures++; $display("FAIL valid_while_training got=%b exp=0", dat_valid); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pulse_cnt[i] - base[i] != 0) begin
                failures++;
                $display("FAIL aligned_pulses lane=%0d got=%0d exp=0", i, pulse_cnt[i] - base[i]);
            end
        end
        train_en = 1'b0;
        repeat (2) tick();
        checks++;
        if (dat_valid !== 1'b1) begin failures++; $display("FAIL aligned_dat_valid got=%b exp=1", dat_valid); end
    endtask

    task automatic test_slip_lane2();
        bit got;
        got = 0;
        off[2] = 3;
        for (int i = 0; i < 4; i++) base[i] = pulse_cnt[i];
        train_en = 1'b1;
        for (int t = 0; t < 200 && !got; t++) begin
            tick();
            if (all_locked === 1'b1 && lane_locked === 4'hF) got = 1;
        end
        checks++;
        if (!got) begin failures++; $display("FAIL slip2_lock got=%b exp=1111", lane_locked); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pulse_cnt[i] - base[i] != ((i == 2) ? 3 : 0)) begin
                failures++;
                $display("FAIL slip2_pulses lane=%0d got=%0d exp=%0d", i, pulse_cnt[i] - base[i], (i == 2) ? 3 : 0);
            end
        end
        train_en = 1'b0;
        tick();
    endtask

    task automatic test_fail_lane0();
        bit got;
        got = 0;
        ovr_en[0]  = 1'b1;
        ovr_val[0] = 7'h00;
        for (int i = 0; i < 4; i++) base[i] = pulse_cnt[i];
        train_en = 1'b1;
        for (int t = 0; t < 200 && !got; t++) begin
            tick();
            if (lane_fail[0] === 1'b1) got = 1;
        end
        repeat (3) tick();
        checks++;
        if (!got) begin failures++; $display("FAIL fail0_timeout got=%b exp=0001", lane_fail); end
        checks++;
        if (pulse_cnt[0] - base[0] != 14) begin failures++; $display("FAIL fail0_pulses got=%0d exp=14", pulse_cnt[0] - base[0]); end
        checks++;
        if (lane_fail !== 4'b0001) begin failures++; $display("FAIL fail0_lane_fail got=%b exp=0001", lane_fail); end
        checks++;
        if (lane_locked !== 4'b1110) begin failures++; $display("FAIL fail0_lane_locked got=%b exp=1110", lane_locked); end
        checks++;
        if (all_locked !== 1'b0) begin failures++; $display("FAIL fail0_all_locked got=%b exp=0", all_locked); end
        ovr_en[0] = 1'b0;
        off[0]    = 0;
        train_en  = 1'b0;
        tick();
    endtask

    task automatic test_corrupt_lane1();
        int lock_t;
        logic [3:0] mid;
        lock_t = 0;
        mid = 4'hx;
        follow[1] = 1'b0;
        for (int i = 0; i < 4; i++) base[i] = pulse_cnt[i];
        train_en = 1'b1;
        repeat (10) tick();
        ovr_en[1]  = 1'b1;
        ovr_val[1] = ~PAT;
        tick();
        ovr_en[1] = 1'b0;
        for (int t = 12; t <= 80 && lock_t == 0; t++) begin
            tick();
            if (t == 17) mid = lane_locked;
            if (lane_locked[1] === 1'b1) lock_t = t;
        end
        checks++;
        if (mid !== 4'b1101) begin failures++; $display("FAIL corrupt_counter_clear got=%b exp=1101", mid); end
        checks++;
        if (lock_t < 32) begin failures++; $display("FAIL corrupt_relock_tick got=%0d exp>=32", lock_t); end
        checks++;
        if (pulse_cnt[1] - base[1] != 1) begin failures++; $display("FAIL corrupt_pulses got=%0d exp=1", pulse_cnt[1] - base[1]); end
        follow[1] = 1'b1;
        train_en  = 1'b0;
        tick();
    endtask

    task automatic test_reset_wait_lane3();
        bit got;
        int exp_p;
        got = 0;
        off[3] = 3;
        for (int i = 0; i < 4; i++) base[i] = pulse_cnt[i];
        train_en = 1'b1;
        for (int t = 0; t < 20 && !got; t++) begin
            tick();
            if (pulse_cnt[3] != base[3]) got = 1;
        end
        checks++;
        if (!got) begin failures++; $display("FAIL rstwait_first_pulse got=0 exp=1"); end
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bitslip !== 4'h0 || lane_locked !== 4'h0 || lane_fail !== 4'h0) begin
            failures++;
            $display("FAIL rstwait_lane_outputs got=%b/%b/%b exp=0", bitslip, lane_locked, lane_fail);
        end
        checks++;
        if (all_locked !== 1'b0 || dat_valid !== 1'b0 || dat_out !== 28'h0) begin
            failures++;
            $display("FAIL rstwait_data_outputs got=%b/%b/%h exp=0", all_locked, dat_valid, dat_out);
        end
        repeat (3) tick();
        for (int i = 0; i < 4; i++) base[i] = pulse_cnt[i];
        exp_p = off[3];
        rst_n = 1'b1;
        got = 0;
        for (int t = 0; t < 100 && !got; t++) begin
            tick();
            if (all_locked === 1'b1 && lane_locked === 4'hF) got = 1;
        end
        checks++;
        if (!got) begin failures++; $display("FAIL rstwait_relock got=%b exp=1111", lane_locked); end
        checks++;
        if (pulse_cnt[3] - base[3] != exp_p) begin
            failures++;
            $display("FAIL rstwait_pulses got=%0d exp=%0d", pulse_cnt[3] - base[3], exp_p);
        end
        train_en = 1'b0;
        tick();
    endtask

    task automatic test_retrain();
        bit got;
        got = 0;
        checks++;
        if (all_locked !== 1'b1) begin failures++; $display("FAIL retrain_pre_lock got=%b exp=1", all_locked); end
        for (int i = 0; i < 4; i++) base[i] = pulse_cnt[i];
        train_en = 1'b1;
        tick();
        checks++;
        if (lane_locked !== 4'h0) begin failures++; $display("FAIL retrain_clear got=%b exp=0000", lane_locked); end
        for (int t = 0; t < 40 && !got; t++) begin
            tick();
            if (all_locked === 1'b1 && lane_locked === 4'hF) got = 1;
        end
        checks++;
        if (!got) begin failures++; $display("FAIL retrain_relock got=%b exp=1111", lane_locked); end
        checks++;
        if (pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3] !=
            base[0] + base[1] + base[2] + base[3]) begin
            failures++;
            $display("FAIL retrain_pulses got=%0d exp=0",
                     pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3] - base[0] - base[1] - base[2] - base[3]);
        end
        train_en = 1'b0;
        repeat (2) tick();
        checks++;
        if (dat_valid !== 1'b1) begin failures++; $display("FAIL retrain_dat_valid got=%b exp=1", dat_valid); end
    endtask

    initial begin
        clkdiv   = 1'b0;
        rst_n    = 1'b0;
        train_en = 1'b0;
        dat_in   = '0;
        checks   = 0;
        failures = 0;
        cyc      = 0;
        for (int i = 0; i < 4; i++) begin
            off[i]        = 0;
            follow[i]     = 1'b1;
            ovr_en[i]     = 1'b0;
            ovr_val[i]    = 7'h00;
            pulse_cnt[i]  = 0;
            last_pulse[i] = -1;
            base[i]       = 0;
        end
        test_reset();
        test_aligned();
        test_slip_lane2();
        test_fail_lane0();
        test_corrupt_lane1();
        test_reset_wait_lane3();
        test_retrain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
